// File: rtl/mem_link_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_link_bridge
// Brief    : Data-bus to byte-link bridge: builds checksummed, seq-tagged
//            frames, validates host responses, resends on timeout, flags abandon.
// Revision : 1.0 - initial release
// ============================================================================
module mem_link_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int MAX_RETRY   = 3,
  parameter int WRITE_ACK   = 0
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              db_re,
  input  logic              db_we,
  input  logic              db_io,
  input  logic [ADDR_W-1:0] db_addr,
  input  logic [DATA_W-1:0] db_dataOut,
  output logic [DATA_W-1:0] db_dataIn,
  output logic              db_ready,
  output logic              db_err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);

  localparam int c_abytes  = ADDR_W / 8;
  localparam int c_dbytes  = DATA_W / 8;
  localparam int c_max_len = 2 + c_abytes + c_dbytes;
  localparam int c_len_w   = $clog2(c_max_len + 1);
  localparam int c_tmr_w   = $clog2(TIMEOUT_CYC);

  localparam logic [3:0] c_cmd_none  = 4'd0;
  localparam logic [3:0] c_cmd_read  = 4'd1;
  localparam logic [3:0] c_cmd_write = 4'd2;
  localparam logic [3:0] c_cmd_print = 4'd3;
  localparam logic [3:0] c_cmd_hlt   = 4'd4;

  localparam logic [c_tmr_w-1:0] c_tmr_last     = c_tmr_w'(TIMEOUT_CYC - 1);
  localparam logic [7:0]         c_retry_max    = 8'(MAX_RETRY);
  localparam logic [c_len_w-1:0] c_rx_last_read = c_len_w'(c_dbytes + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t               r_state, w_next_state;
  logic [7:0]           r_frame [c_max_len];
  logic [7:0]           w_frame [c_max_len];
  logic [c_len_w-1:0]   r_len, w_len, r_tx_idx, r_rx_idx, w_rx_last;
  logic [3:0]           r_seq, r_cmd, w_cmd;
  logic                 r_need_wait, w_need_wait;
  logic [7:0]           r_retries;
  logic [c_tmr_w-1:0]   r_timer;
  logic [7:0]           r_rx_csum, w_csum, w_tx_byte;
  logic                 r_hdr_ok;
  logic [DATA_W-1:0]    r_rx_buf;
  logic                 w_accept, w_tx_last, w_rx_final, w_rx_ok, w_timeout;

  // Command decode; IO accesses other than the two known ports are dropped.
  always_comb begin
    w_cmd = c_cmd_none;
    if (db_io) begin
      if (db_we && (db_addr == '0))
        w_cmd = c_cmd_hlt;
      else if (db_we && (db_addr == ADDR_W'(1)))
        w_cmd = c_cmd_print;
    end else if (db_we) begin
      w_cmd = c_cmd_write;
    end else if (db_re) begin
      w_cmd = c_cmd_read;
    end
  end

  // Whole frame is assembled at acceptance so resends replay a frozen copy.
  always_comb begin
    for (int i = 0; i < c_max_len; i++) w_frame[i] = 8'h00;
    w_frame[0] = {r_seq, w_cmd};
    w_len      = c_len_w'(2);
    case (w_cmd)
      c_cmd_read: begin
        for (int i = 0; i < c_abytes; i++) w_frame[1 + i] = db_addr[8*i +: 8];
        w_len = c_len_w'(2 + c_abytes);
      end
      c_cmd_write: begin
        for (int i = 0; i < c_abytes; i++) w_frame[1 + i] = db_addr[8*i +: 8];
        for (int i = 0; i < c_dbytes; i++) w_frame[1 + c_abytes + i] = db_dataOut[8*i +: 8];
        w_len = c_len_w'(2 + c_abytes + c_dbytes);
      end
      c_cmd_print: begin
        for (int i = 0; i < c_dbytes; i++) w_frame[1 + i] = db_dataOut[8*i +: 8];
        w_len = c_len_w'(2 + c_dbytes);
      end
      default: ;
    endcase
    w_csum = 8'h00;
    for (int i = 0; i < c_max_len; i++) w_csum = w_csum ^ w_frame[i];
    for (int i = 0; i < c_max_len; i++)
      if (c_len_w'(i) == (w_len - c_len_w'(1))) w_frame[i] = w_csum;
  end

  always_comb begin
    w_tx_byte = 8'h00;
    for (int i = 0; i < c_max_len; i++)
      if (r_tx_idx == c_len_w'(i)) w_tx_byte = r_frame[i];
  end

  assign w_accept    = (r_state == S_IDLE) && (w_cmd != c_cmd_none);
  assign w_need_wait = (w_cmd == c_cmd_read) || ((w_cmd == c_cmd_write) && (WRITE_ACK != 0));
  assign w_tx_last   = (r_tx_idx == (r_len - c_len_w'(1)));
  assign w_rx_last   = (r_cmd == c_cmd_read) ? c_rx_last_read : c_len_w'(1);
  assign w_rx_final  = (r_state == S_WAIT) && rx_valid && (r_rx_idx == w_rx_last);
  assign w_rx_ok     = w_rx_final && r_hdr_ok && ((r_rx_csum ^ rx_data) == 8'h00);
  assign w_timeout   = (r_state == S_WAIT) && (r_timer == c_tmr_last);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    db_ready     = 1'b0;
    db_err       = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    case (r_state)
      S_IDLE: begin
        db_ready = 1'b1;
        if (w_accept) w_next_state = S_TX;
      end
      S_TX: begin
        tx_valid = 1'b1;
        tx_data  = w_tx_byte;
        if (tx_ready && w_tx_last) w_next_state = r_need_wait ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        // A completing response beats a coincident timeout.
        if (w_rx_ok)        w_next_state = S_IDLE;
        else if (w_timeout) w_next_state = (r_retries < c_retry_max) ? S_TX : S_ERR;
      end
      S_ERR: begin
        db_err       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < c_max_len; i++) r_frame[i] <= 8'h00;
      r_len       <= '0;
      r_tx_idx    <= '0;
      r_rx_idx    <= '0;
      r_cmd       <= c_cmd_none;
      r_seq       <= 4'd0;
      r_need_wait <= 1'b0;
      r_retries   <= 8'd0;
      r_timer     <= '0;
      r_rx_csum   <= 8'h00;
      r_hdr_ok    <= 1'b0;
      r_rx_buf    <= '0;
      db_dataIn   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < c_max_len; i++) r_frame[i] <= w_frame[i];
            r_len       <= w_len;
            r_cmd       <= w_cmd;
            r_need_wait <= w_need_wait;
            r_seq       <= r_seq + 4'd1;
            r_retries   <= 8'd0;
            r_tx_idx    <= '0;
          end
        end
        S_TX: begin
          if (tx_ready) begin
            r_tx_idx <= r_tx_idx + c_len_w'(1);
            if (w_tx_last) begin
              r_timer   <= '0;
              r_rx_idx  <= '0;
              r_rx_csum <= 8'h00;
            end
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + c_tmr_w'(1);
          if (rx_valid) begin
            if (r_rx_idx == '0) r_hdr_ok <= (rx_data == r_frame[0]);
            if (w_rx_final) begin
              r_rx_idx  <= '0;
              r_rx_csum <= 8'h00;
            end else begin
              // Header is shifted through too; D data shifts push it out.
              r_rx_idx  <= r_rx_idx + c_len_w'(1);
              r_rx_csum <= r_rx_csum ^ rx_data;
              r_rx_buf  <= (r_rx_buf >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
            end
          end
          if (w_rx_ok && (r_cmd == c_cmd_read)) db_dataIn <= r_rx_buf;
          if (w_timeout && !w_rx_ok && (r_retries < c_retry_max)) begin
            r_retries <= r_retries + 8'd1;
            r_tx_idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_link_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_link_bridge
// Brief    : Self-checking bench with a transaction-level model and host stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_link_bridge;

  localparam int AW = 32, DW = 32, TO = 50, MR = 2, WA = 0;
  localparam int NA = AW / 8, ND = DW / 8;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          db_re = 1'b0, db_we = 1'b0, db_io = 1'b0;
  logic [AW-1:0] db_addr = '0;
  logic [DW-1:0] db_dataOut = '0;
  logic [DW-1:0] db_dataIn;
  logic          db_ready, db_err, tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;

  always #5 clk = ~clk;

  mem_link_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR), .WRITE_ACK(WA)
  ) dut (
    .clk(clk), .res_n(res_n), .db_re(db_re), .db_we(db_we), .db_io(db_io),
    .db_addr(db_addr), .db_dataOut(db_dataOut), .db_dataIn(db_dataIn),
    .db_ready(db_ready), .db_err(db_err), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum {P_IDLE, P_SEND, P_WAIT, P_ERR} ph_t;
  ph_t        ph;
  logic [7:0] frame[$];
  logic [7:0] rxq[$];
  int         pos, cnt, tries, attempt;
  bit         need_wait;
  logic [3:0] mcmd, mseq;
  logic [DW-1:0] m_din;

  // host stub and byte monitor
  logic [7:0]    hq[$];
  logic [7:0]    dut_bytes[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    lit[$];
  int            hgap, reply_mode, err_seen;
  bit            noise_en;
  logic [DW-1:0] host_val;

  function automatic logic [3:0] decode(input logic re, input logic we, input logic io,
                                        input logic [AW-1:0] a);
    if (io) return (we && a == 0) ? 4'd4 : (we && a == 1) ? 4'd3 : 4'd0;
    if (we) return 4'd2;
    if (re) return 4'd1;
    return 4'd0;
  endfunction

  task automatic build_frame(input logic [3:0] c, input logic [3:0] sq,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [7:0] x;
    frame.delete();
    frame.push_back({sq, c});
    if (c == 1 || c == 2) for (int i = 0; i < NA; i++) frame.push_back(a[8*i +: 8]);
    if (c == 2 || c == 3) for (int i = 0; i < ND; i++) frame.push_back(d[8*i +: 8]);
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(x);
  endtask

  task automatic build_reply();
    logic [7:0] x, h;
    hq.delete();
    if (reply_mode == 0) return;
    h = frame[0];
    if (reply_mode == 3 && attempt == 1) h[7:4] = h[7:4] + 4'd1;
    hq.push_back(h);
    if (mcmd == 1) for (int i = 0; i < ND; i++) hq.push_back(host_val[8*i +: 8]);
    x = 8'h00;
    foreach (hq[i]) x ^= hq[i];
    if (reply_mode == 2 && attempt == 1) x ^= 8'h5A;
    hq.push_back(x);
    // mode 4 lands the final byte exactly on the timeout cycle
    hgap = (reply_mode == 4) ? TO - hq.size() : int'($urandom_range(0, 5));
  endtask

  task automatic model_reset();
    ph = P_IDLE; mseq = 4'd0; m_din = '0; tries = 0; cnt = 0; pos = 0;
    frame.delete(); rxq.delete(); hq.delete();
  endtask

  task automatic model_update();
    logic [3:0] c;
    logic [7:0] x;
    bit done;
    case (ph)
      P_IDLE: begin
        c = decode(db_re, db_we, db_io, db_addr);
        if (c != 0) begin
          mcmd = c;
          build_frame(c, mseq, db_addr, db_dataOut);
          mseq = mseq + 4'd1;
          need_wait = (c == 1) || (c == 2 && WA != 0);
          pos = 0; tries = 0; attempt = 1; ph = P_SEND;
        end
      end
      P_SEND: if (tx_ready) begin
        pos++;
        if (pos == frame.size()) begin
          if (need_wait) begin
            ph = P_WAIT; cnt = 0; rxq.delete(); build_reply();
          end else ph = P_IDLE;
        end
      end
      P_WAIT: begin
        done = 0;
        if (rx_valid) begin
          rxq.push_back(rx_data);
          if (rxq.size() == ((mcmd == 1) ? ND + 2 : 2)) begin
            x = 8'h00;
            foreach (rxq[i]) x ^= rxq[i];
            if (rxq[0] == frame[0] && x == 8'h00) begin
              done = 1;
              if (mcmd == 1) for (int i = 0; i < ND; i++) m_din[8*i +: 8] = rxq[1 + i];
              ph = P_IDLE;
            end
            rxq.delete();
          end
        end
        if (!done) begin
          if (cnt == TO - 1) begin
            if (tries < MR) begin
              tries++; attempt++; pos = 0; ph = P_SEND; hq.delete();
            end else ph = P_ERR;
          end else cnt++;
        end
      end
      P_ERR: ph = P_IDLE;
    endcase
  endtask

  task automatic compare();
    chk("db_ready", db_ready, ph == P_IDLE);
    chk("db_err", db_err, ph == P_ERR);
    chk("tx_valid", tx_valid, ph == P_SEND);
    if (ph == P_SEND) chk("tx_data", tx_data, frame[pos]);
    chk("db_dataIn", db_dataIn, m_din);
    if (db_err) err_seen++;
  endtask

  task automatic host_drive();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (ph == P_WAIT && hq.size() > 0) begin
      if (hgap > 0) hgap--;
      else begin
        rx_valid = 1'b1;
        rx_data  = hq.pop_front();
        hgap = (reply_mode == 4) ? 0 : int'($urandom_range(0, 2));
      end
    end else if (ph != P_WAIT && noise_en && $urandom_range(0, 9) == 0) begin
      rx_valid = 1'b1;
    end
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step();
    host_drive();
    if (tx_valid && tx_ready) dut_bytes.push_back(tx_data);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic request(input logic re, input logic we, input logic io,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int mode, input logic [DW-1:0] hv, input int rdy_pct);
    int budget;
    budget = 0;
    while (ph != P_IDLE && budget < 1000) begin step(); budget++; end
    reply_mode = mode; host_val = hv;
    db_re = re; db_we = we; db_io = io; db_addr = a; db_dataOut = d;
    step();
    db_re = 1'b0; db_we = 1'b0; db_io = 1'b0; db_addr = AW'($urandom); db_dataOut = DW'($urandom);
    budget = 0;
    do begin
      tx_ready = ($urandom_range(1, 100) <= rdy_pct);
      step();
      budget++;
    end while (ph != P_IDLE && budget < 2000);
    chk("request_completes", db_ready, 1'b1);
  endtask

  task automatic expect_frames(input string name, input int n);
    exp_q.delete();
    repeat (n) foreach (lit[i]) exp_q.push_back(lit[i]);
    chk({name, "_len"}, 64'(dut_bytes.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      chk(name, (i < dut_bytes.size()) ? {56'd0, dut_bytes[i]} : 64'hBAD, {56'd0, exp_q[i]});
  endtask

  task automatic check_reset_vals();
    chk("rst_db_ready", db_ready, 1'b1);
    chk("rst_db_err", db_err, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_db_dataIn", db_dataIn, '0);
  endtask

  task automatic pulse_reset();
    #2 res_n = 1'b0;
    model_reset();
    #1 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic re, we, io;
    logic [AW-1:0] a;
    int r, mode, guard;

    model_reset();
    noise_en = 0; err_seen = 0; reply_mode = 0; host_val = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals();
    res_n = 1'b1;
    @(negedge clk);

    // posted write, seq 0
    dut_bytes.delete();
    request(0, 1, 0, 32'h10, 32'hDEADBEEF, 1, 0, 100);
    lit = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h30};
    expect_frames("write_frame", 1);

    // read, seq 1, good reply
    dut_bytes.delete();
    request(1, 0, 0, 32'h4, 0, 1, 32'h12345678, 100);
    lit = '{8'h11, 8'h04, 8'h00, 8'h00, 8'h00, 8'h15};
    expect_frames("read_frame", 1);
    chk("read_data", db_dataIn, 32'h12345678);

    // bad checksum first, then correct reply on the resend
    dut_bytes.delete();
    request(1, 0, 0, 32'h8, 0, 2, 32'hCAFEF00D, 70);
    lit = '{8'h21, 8'h08, 8'h00, 8'h00, 8'h00, 8'h29};
    expect_frames("resend_frames", 2);
    chk("resend_data", db_dataIn, 32'hCAFEF00D);

    // no reply: three transmissions then a single error pulse
    dut_bytes.delete(); err_seen = 0;
    request(1, 0, 0, 32'hC, 0, 0, 0, 100);
    lit = '{8'h31, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h3D};
    expect_frames("abandon_frames", 3);
    chk("abandon_err_pulses", 64'(err_seen), 64'd1);
    chk("abandon_data_kept", db_dataIn, 32'hCAFEF00D);

    // IO commands
    dut_bytes.delete();
    request(0, 1, 1, 32'h0, 0, 1, 0, 100);
    lit = '{8'h44, 8'h44};
    expect_frames("hlt_frame", 1);
    dut_bytes.delete();
    request(0, 1, 1, 32'h1, 32'h41, 1, 0, 100);
    lit = '{8'h53, 8'h41, 8'h00, 8'h00, 8'h00, 8'h12};
    expect_frames("print_frame", 1);
    dut_bytes.delete();
    request(0, 1, 1, 32'h7, 32'h99, 1, 0, 100);
    request(1, 0, 1, 32'h0, 0, 1, 0, 100);
    chk("io_ignored_bytes", 64'(dut_bytes.size()), 64'd0);

    // final reply byte coincides with the timeout cycle
    dut_bytes.delete();
    request(1, 0, 0, 32'h20, 0, 4, 32'h0BADF00D, 100);
    lit = '{8'h61, 8'h20, 8'h00, 8'h00, 8'h00, 8'h41};
    expect_frames("tie_frames", 1);
    chk("tie_data", db_dataIn, 32'h0BADF00D);

    // randomized traffic
    noise_en = 1;
    for (int n = 0; n < 50; n++) begin
      io = ($urandom_range(0, 4) == 0);
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 2)) : AW'($urandom);
      r  = $urandom_range(0, 9);
      mode = (r == 0) ? 0 : (r < 3) ? 2 : (r < 5) ? 3 : (r == 5) ? 4 : 1;
      request(re, we, io, a, DW'($urandom), mode, DW'($urandom), $urandom_range(30, 100));
    end
    noise_en = 0;

    // stall mid-frame, then reset while waiting
    reply_mode = 0;
    db_re = 1'b1; db_addr = 32'h30; tx_ready = 1'b0;
    step();
    db_re = 1'b0;
    tx_ready = 1'b1; step(); step();
    tx_ready = 1'b0; repeat (5) step();
    tx_ready = 1'b1;
    guard = 0;
    while (ph != P_WAIT && guard < 100) begin step(); guard++; end
    chk("stall_reached_wait", 64'(ph == P_WAIT), 64'd1);
    repeat (10) step();
    pulse_reset();
    dut_bytes.delete();
    request(0, 1, 0, 32'h44, 32'h01020304, 1, 0, 100);
    lit = '{8'h02, 8'h44, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h42};
    expect_frames("post_reset_frame", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_link_bridge.md
# mem_link_bridge

Parametrised successor to the UART memory bridge: it converts data-bus read/write/IO requests into checksummed, sequence-tagged byte frames for the host link, then collects and validates the host's response. It is configurable in address and data width, can optionally wait for write acknowledgements, and gives up after a bounded number of retries with an explicit error pulse. It sits between the CPU data bus and a byte-stream serializer/deserializer pair (UART or similar). The serializer pair is outside this block.

## Interface
- ADDR_W, 32, bus address width; multiple of 8; A = ADDR_W/8 bytes
- DATA_W, 32, bus data width; multiple of 8; D = DATA_W/8 bytes
- TIMEOUT_CYC, 2500000, response wait in clk cycles before resend; ≥2
- MAX_RETRY, 3, number of resends allowed before error; 0–255
- WRITE_ACK, 0, 1 = writes wait for an ACK frame; 0 = writes are fire-and-forget
- clk  in  1  system clock
- res_n  in  1  reset; asynchronous assertion, active-low
- db_re, db_we, db_io  in  1 each  bus read strobe, write strobe, IO qualifier
- db_addr  in  ADDR_W  bus address
- db_dataOut  in  DATA_W  write data
- db_dataIn  out  DATA_W  last read data (registered)
- db_ready  out  1  high only in IDLE
- db_err  out  1  one-cycle pulse when a request is abandoned
- tx_data  out  8  outgoing byte
- tx_valid  out  1  byte valid
- tx_ready  in  1  serializer accepts the byte
- rx_data  in  8  incoming byte
- rx_valid  in  1  one-cycle strobe per received byte; there is no backpressure

## Operation
- Command decode in IDLE:
  - db_io & db_we & addr==0 → HLT (4)
  - db_io & db_we & addr==1 → PRINT (3)
  - Any other db_io access → ignored; no frame is sent and db_ready stays high
  - db_we → WRITE (2)
  - db_re → READ (1)
  - If db_we and db_re are both asserted, write wins.
- Acceptance: on a clk edge in IDLE with a valid command, the block latches cmd, addr, data and needWait into a frame buffer.
  - needWait = READ, or (WRITE & WRITE_ACK).
  - seq (4-bit) is used for this request, then increments mod 16 on acceptance only. Resends reuse the same seq.
- Outgoing frame, all multi-byte fields LSB byte first:
  - Header byte {seq, cmd[3:0]}
  - READ: header, addr; length 2+A
  - WRITE: header, addr, data; length 2+A+D
  - PRINT: header, data; length 2+D
  - HLT: header only; length 2
  - Each frame ends with one checksum byte = XOR of all preceding frame bytes (this byte is included in the lengths above).
- Response frames:
  - READ: {seq,4'h1}, D data bytes, checksum
  - Write ACK: {seq,4'h2}, checksum
  - A response is valid iff the header matches the outstanding {seq,cmd} and the XOR of all response bytes (checksum included) equals 0.
  - On an invalid response the block discards the frame and resets the receive byte index. It keeps waiting without restarting the timeout counter.
- States:
  - IDLE: db_ready=1.
  - TX: emit bytes. After the last byte is taken, go to WAIT if needWait, else IDLE.
  - WAIT: count cycles and collect bytes.
    - Valid response → latch data into db_dataIn (READ only) → IDLE.
    - Counter reaches TIMEOUT_CYC-1 with retries<MAX_RETRY → retries++, go to TX and replay the whole frame. Any partial response is dropped.
    - Counter reaches TIMEOUT_CYC-1 with retries==MAX_RETRY → ERR.
  - ERR: db_err=1 for exactly one cycle; db_dataIn unchanged; then IDLE.
  - Retry count clears on acceptance.
- rx bytes arriving outside WAIT are discarded.

## Timing
- Reset values:
  - state=IDLE, db_ready=1, db_err=0
  - tx_valid=0, tx_data=0
  - db_dataIn=0, seq=0, retries=0, timeout counter=0
- Acceptance edge k: db_ready=0 and tx_valid=1 with the header from cycle k+1.
- A byte transfers on each edge with tx_valid&tx_ready; the next byte appears in the following cycle. tx_data is held stable while tx_ready=0.
- After the final byte is transferred, tx_valid=0 in the next cycle.
- Non-wait commands: db_ready=1 in the cycle after the final byte transfer.
- WAIT: the timeout counter is 0 on entry and increments each cycle. Timeout fires in cycle TIMEOUT_CYC-1 after entry, and the first resend byte is valid in the next cycle.
- Valid response: the final rx byte is accepted on edge m; db_dataIn is updated and db_ready=1 from cycle m+1.
- If a valid final rx byte and the timeout occur in the same cycle, the response wins.
- res_n asserted mid-frame: abort immediately to reset values; no partial frame resumes.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, seq 0, WRITE_ACK=0 → tx bytes 02 10 00 00 00 EF BE AD DE 30; db_ready returns high after byte 10; no rx needed.
- Read addr 0x4 with seq 1 (after one prior command); host returns 11 78 56 34 12 19 → tx bytes 11 04 00 00 00 15; db_dataIn=0x12345678, db_ready=1 the cycle after the 0x19 byte.
- Read with host reply 11 78 56 34 12 00 (bad checksum), TIMEOUT_CYC=50 → frame discarded; after 50 cycles the identical frame is resent with the same seq; a correct reply then completes the read.
- Read with no reply, MAX_RETRY=2 → exactly 3 frame transmissions, then db_err high for 1 cycle, db_dataIn unchanged, db_ready=1; the next request uses seq+1.
- IO write addr 0 → bytes 24 24 (seq 2); IO write addr 1 data 0x41 → bytes 33 41 00 00 00 72; IO write addr 7 → no tx_valid, db_ready stays 1.
- tx_ready held low 5 cycles mid-frame, then res_n pulsed low during WAIT → tx_data stable while stalled; after reset all outputs match the reset values and the next frame header uses seq 0.
